dram_rw_arbiter: RTL and testbench
==================================

Name: dram_rw_arbiter

Overview:
- Single-clock arbiter that shares one DRAM command port between two requesters.
- Read requester: the HDMI line-prefetch address generator (display scan-out).
- Write requester: the UDP frame receiver's burst writer.
- Reads have priority to protect the display FIFO. A starvation limit guarantees the write path progresses.
- Exactly one command is outstanding at a time. Sits between the requesters and the DRAM controller's command interface.

Parameters:
- ADDR_W, 32, address width for all ports.
- LEN_W, 32, command length width (beats). Write length is zero-extended into it.
- STARVE_MAX, 4, consecutive read grants allowed while a write is pending before the write is forced.
- TIMEOUT_CYCLES, 65535, watchdog limit in clk cycles (only used with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock (DRAM/user clock domain)
- rst  in  1  synchronous, active-high reset
- rd_req  in  1  read request; level, held until rd_ack
- rd_addr  in  ADDR_W  read byte address; stable while rd_req
- rd_num  in  LEN_W  read beats; stable while rd_req
- rd_ack  out  1  one-cycle pulse when the read command is accepted downstream
- rd_busy  out  1  high while a read command is outstanding
- wr_req  in  1  write request; level, held until wr_ack
- wr_addr  in  ADDR_W  write byte address
- wr_len  in  8  write burst length field (beats-1, as in the ctrl word len[39:32])
- wr_ack  out  1  one-cycle pulse when the write command is accepted
- wr_busy  out  1  high while a write command is outstanding
- cmd_valid  out  1  command valid to the DRAM controller
- cmd_ready  in  1  DRAM controller accepts the command when valid&&ready
- cmd_write  out  1  1 = write, 0 = read
- cmd_addr  out  ADDR_W  command address
- cmd_len  out  LEN_W  read: rd_num; write: {0, wr_len}+1
- cmd_done  in  1  one-cycle pulse; the outstanding command has completed
- err_timeout  out  1  sticky watchdog flag (constant 0 when the feature is off)

Behaviour:
- Reset values: every output is 0; FSM=IDLE; starve_cnt=0.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE, grant decision:
  - Grant write if wr_req && (!rd_req || starve_cnt==STARVE_MAX).
  - Otherwise grant read if rd_req.
  - On a grant, latch the selected addr/len/dir into the cmd_* registers, assert cmd_valid next cycle, go to ISSUE. Minimum latency from request to cmd_valid is 1 cycle.
- ISSUE:
  - Hold cmd_valid and all cmd_* fields stable until cmd_ready.
  - On valid&&ready, in the same cycle: drop cmd_valid next cycle; pulse rd_ack or wr_ack for 1 cycle; set rd_busy or wr_busy; go to WAIT_DONE.
- WAIT_DONE:
  - On cmd_done: clear the busy flag; go to IDLE.
  - A new grant may be issued in the following IDLE cycle, so back-to-back issue spacing is 1 idle cycle.
  - cmd_done arriving in ISSUE or IDLE is ignored.
- starve_cnt:
  - +1 on each read grant while wr_req is high, saturating at STARVE_MAX.
  - Reset to 0 on any write grant, or on a read grant while wr_req is low.
- Requester rule: a requester may only drop req after its ack. A req dropped while in ISSUE does not cancel the command; the command completes normally.
- cmd_len arithmetic: the write length is wr_len+1 computed in LEN_W bits, so 8'hFF gives 256. rd_num=0 is forwarded unchanged, with no special case.
- rst mid-operation returns the FSM to IDLE immediately and drops cmd_valid. The DRAM controller is reset by the same rst.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT_DONE and clears on state entry.
  - On reaching TIMEOUT_CYCLES: set err_timeout (sticky until rst), clear both busy flags, go to IDLE.
- When not defined: no counter is built; err_timeout is tied to 0; WAIT_DONE waits indefinitely.

Decomposition:
- Shared package (dram_arb_pkg):
  - FSM state enum {IDLE, ISSUE, WAIT_DONE}.
  - Direction constants CMD_RD=0, CMD_WR=1.
  - Default ADDR_W and LEN_W.
- No sub-module is needed; the grant logic, starvation counter and FSM stay in one module.

Test Plan:
- Read only: rd_req with addr=0x1000_0000, num=400; cmd_ready=1 → cmd_valid 1 cycle later with cmd_write=0, cmd_len=400; rd_ack pulse; rd_busy=1 until cmd_done.
- Write only: wr_len=8'h0F, addr=0x2000_0040 → cmd_write=1, cmd_len=16; wr_ack 1 pulse; wr_busy cleared by cmd_done.
- Contention: rd_req and wr_req held continuously with STARVE_MAX=4 → grant order R,R,R,R,W,R,R,R,R,W.
- Backpressure: cmd_ready low for 10 cycles in ISSUE → cmd_* fields stable, no ack pulse; ack fires on the cycle cmd_ready rises.
- Reset mid-operation: rst asserted during ISSUE and during WAIT_DONE → next cycle all outputs 0 and FSM=IDLE; a new rd_req is then granted normally.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100: no cmd_done after accept → err_timeout=1 after 100 cycles, busy flags clear, the next request is served; err_timeout stays 1 until rst.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM read/write command arbiter.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone
  } arb_state_e;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefLenW  = 32;

endpackage

// File: rtl/dram_rw_arbiter.sv
// Read-priority arbiter sharing one DRAM command port between a read and a write requester.
// Optional command watchdog is built when ARB_TIMEOUT_EN is defined.
module dram_rw_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned LEN_W          = DefLenW,
  parameter int unsigned STARVE_MAX     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_num,
  output logic              rd_ack,
  output logic              rd_busy,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_len,
  output logic              wr_ack,
  output logic              wr_busy,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_done,
  output logic              err_timeout
);

  localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  if (TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("TIMEOUT_CYCLES must be non-zero");
  end

  arb_state_e state_q, state_d;

  logic               cmd_valid_q, cmd_valid_d;
  logic               cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0]  cmd_addr_q,  cmd_addr_d;
  logic [LEN_W-1:0]   cmd_len_q,   cmd_len_d;
  logic               rd_busy_q,   rd_busy_d;
  logic               wr_busy_q,   wr_busy_d;
  logic [StarveW-1:0] starve_q,    starve_d;

  logic grant_wr, grant_rd, accept, timeout;

  // Reads win unless the write has already waited STARVE_MAX read grants.
  assign grant_wr = (state_q == StIdle) && wr_req &&
                    (!rd_req || (starve_q == StarveW'(STARVE_MAX)));
  assign grant_rd = (state_q == StIdle) && rd_req && !grant_wr;
  assign accept   = (state_q == StIssue) && cmd_valid_q && cmd_ready;

`ifdef ARB_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        err_q, err_d;

  assign timeout = (state_q == StWaitDone) && !cmd_done &&
                   (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  // Outside WAIT_DONE the counter sits at zero, so it restarts on every entry.
  always_comb begin
    to_cnt_d = '0;
    err_d    = err_q | timeout;
    if (state_q == StWaitDone) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_wr || grant_rd) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (accept) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (cmd_done || timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Command, busy and starvation datapath.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    rd_busy_d   = rd_busy_q;
    wr_busy_d   = wr_busy_q;
    starve_d    = starve_q;

    if (grant_wr) begin
      cmd_valid_d = 1'b1;
      cmd_write_d = CMD_WR;
      cmd_addr_d  = wr_addr;
      cmd_len_d   = LEN_W'(wr_len) + LEN_W'(1);
      starve_d    = '0;
    end else if (grant_rd) begin
      cmd_valid_d = 1'b1;
      cmd_write_d = CMD_RD;
      cmd_addr_d  = rd_addr;
      cmd_len_d   = rd_num;
      if (!wr_req) begin
        starve_d = '0;
      end else if (starve_q != StarveW'(STARVE_MAX)) begin
        starve_d = starve_q + StarveW'(1);
      end
    end

    if (accept) begin
      cmd_valid_d = 1'b0;
      rd_busy_d   = (cmd_write_q == CMD_RD);
      wr_busy_d   = (cmd_write_q == CMD_WR);
    end

    if ((state_q == StWaitDone) && (cmd_done || timeout)) begin
      rd_busy_d = 1'b0;
      wr_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      rd_busy_q   <= 1'b0;
      wr_busy_q   <= 1'b0;
      starve_q    <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      rd_busy_q   <= rd_busy_d;
      wr_busy_q   <= wr_busy_d;
      starve_q    <= starve_d;
    end
  end

  // Outputs; acks are combinational so they coincide with the accepting handshake.
  always_comb begin
    cmd_valid = cmd_valid_q;
    cmd_write = cmd_write_q;
    cmd_addr  = cmd_addr_q;
    cmd_len   = cmd_len_q;
    rd_busy   = rd_busy_q;
    wr_busy   = wr_busy_q;
    rd_ack    = accept && (cmd_write_q == CMD_RD);
    wr_ack    = accept && (cmd_write_q == CMD_WR);
  end

endmodule

// File: tb/tb_dram_rw_arbiter.sv
// Directed self-checking bench for dram_rw_arbiter (STARVE_MAX=4, TIMEOUT_CYCLES=100).
module tb_dram_rw_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [31:0] rd_num = '0;
  logic        rd_ack, rd_busy;
  logic        wr_req = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [7:0]  wr_len = '0;
  logic        wr_ack, wr_busy;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_len;
  logic        cmd_done = 1'b0;
  logic        err_timeout;

  int n_pass  = 0;
  int n_total = 0;

  dram_rw_arbiter #(
    .ADDR_W        (32),
    .LEN_W         (32),
    .STARVE_MAX    (4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_num     (rd_num),
    .rd_ack     (rd_ack),
    .rd_busy    (rd_busy),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_len     (wr_len),
    .wr_ack     (wr_ack),
    .wr_busy    (wr_busy),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_done   (cmd_done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] all_out();
    return {rd_ack, rd_busy, wr_ack, wr_busy, cmd_valid, cmd_write, cmd_addr, cmd_len,
            err_timeout};
  endfunction

  // Finish the outstanding command from WAIT_DONE and return to IDLE.
  task automatic complete();
    cmd_done = 1'b1;
    cyc();
    cmd_done = 1'b0;
  endtask

  logic [31:0] held_addr, held_len;
  logic [9:0]  exp_order;
  logic        got_valid;

  initial begin
    exp_order = 10'b1000010000;  // bit i = direction of grant i: R,R,R,R,W,R,R,R,R,W

    // Reset
    rst = 1'b1;
    cyc();
    cyc();
    check("reset_outputs", all_out(), '0);
    rst = 1'b0;

    // Read only
    rd_req = 1'b1; rd_addr = 32'h1000_0000; rd_num = 32'd400; cmd_ready = 1'b1;
    cyc();
    check("rd_issue", {cmd_valid, cmd_write, cmd_addr, cmd_len, rd_ack, rd_busy},
          {1'b1, 1'b0, 32'h1000_0000, 32'd400, 1'b1, 1'b0});
    rd_req = 1'b0;
    cyc();
    check("rd_wait", {cmd_valid, rd_ack, rd_busy}, {1'b0, 1'b0, 1'b1});
    cyc();
    check("rd_busy_hold", rd_busy, 1'b1);
    complete();
    check("rd_done", {rd_busy, cmd_valid}, '0);

    // Write only
    wr_req = 1'b1; wr_addr = 32'h2000_0040; wr_len = 8'h0F;
    cyc();
    check("wr_issue", {cmd_valid, cmd_write, cmd_addr, cmd_len, wr_ack, rd_ack},
          {1'b1, 1'b1, 32'h2000_0040, 32'd16, 1'b1, 1'b0});
    wr_req = 1'b0;
    cyc();
    check("wr_wait", {cmd_valid, wr_ack, wr_busy}, {1'b0, 1'b0, 1'b1});
    complete();
    check("wr_done", wr_busy, 1'b0);

    // Contention: both requests held for ten grants
    rd_req = 1'b1; wr_req = 1'b1;
    for (int g = 0; g < 10; g++) begin
      got_valid = 1'b0;
      for (int w = 0; w < 4 && !got_valid; w++) begin
        cyc();
        got_valid = cmd_valid;
      end
      check($sformatf("contend_valid%0d", g), got_valid, 1'b1);
      check($sformatf("contend_dir%0d", g), cmd_write, exp_order[g]);
      cyc();
      complete();
    end
    rd_req = 1'b0; wr_req = 1'b0;

    // Boundary lengths: rd_num=0 forwarded, wr_len=FF gives 256
    rd_req = 1'b1; rd_num = 32'd0; rd_addr = 32'h0000_0100;
    cyc();
    check("rd_len_zero", {cmd_valid, cmd_write, cmd_len}, {1'b1, 1'b0, 32'd0});
    rd_req = 1'b0;
    cyc();
    complete();
    wr_req = 1'b1; wr_len = 8'hFF;
    cyc();
    check("wr_len_256", {cmd_valid, cmd_write, cmd_len}, {1'b1, 1'b1, 32'd256});
    wr_req = 1'b0;
    cyc();
    complete();

    // Backpressure: ready low for 10 cycles
    cmd_ready = 1'b0; rd_req = 1'b1; rd_addr = 32'h3000_0080; rd_num = 32'd77;
    cyc();
    held_addr = cmd_addr; held_len = cmd_len;
    check("bp_first", {cmd_valid, cmd_addr, cmd_len, rd_ack},
          {1'b1, 32'h3000_0080, 32'd77, 1'b0});
    for (int i = 0; i < 10; i++) begin
      cyc();
      check($sformatf("bp_hold%0d", i), {cmd_valid, cmd_addr, cmd_len, rd_ack, rd_busy},
            {1'b1, held_addr, held_len, 1'b0, 1'b0});
    end
    cmd_ready = 1'b1;
    #1;
    check("bp_ack", rd_ack, 1'b1);
    rd_req = 1'b0;
    cyc();
    check("bp_busy", {cmd_valid, rd_busy}, {1'b0, 1'b1});
    complete();

    // Reset during ISSUE
    cmd_ready = 1'b0; rd_req = 1'b1; rd_addr = 32'h4000_0000; rd_num = 32'd8;
    cyc();
    check("rst_issue_pre", cmd_valid, 1'b1);
    rst = 1'b1;
    cyc();
    check("rst_issue_outputs", all_out(), '0);
    rst = 1'b0;
    cyc();
    check("rst_issue_regrant", {cmd_valid, cmd_addr}, {1'b1, 32'h4000_0000});
    cmd_ready = 1'b1;
    #1;
    rd_req = 1'b0;
    cyc();
    check("rst_wait_pre", rd_busy, 1'b1);
    // Reset during WAIT_DONE
    rst = 1'b1;
    cyc();
    check("rst_wait_outputs", all_out(), '0);
    rst = 1'b0;
    rd_req = 1'b1; rd_addr = 32'h5000_0000; rd_num = 32'd3;
    cyc();
    check("rst_new_grant", {cmd_valid, cmd_write, cmd_addr, cmd_len, rd_ack},
          {1'b1, 1'b0, 32'h5000_0000, 32'd3, 1'b1});
    rd_req = 1'b0;
    cyc();
    check("rst_new_busy", rd_busy, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // No cmd_done: watchdog fires after 100 cycles in WAIT_DONE
    for (int i = 0; i < 99; i++) cyc();
    check("to_before", {err_timeout, rd_busy}, {1'b0, 1'b1});
    cyc();
    check("to_fire", {err_timeout, rd_busy, wr_busy}, {1'b1, 1'b0, 1'b0});
    wr_req = 1'b1; wr_len = 8'h01;
    cyc();
    check("to_serve", {cmd_valid, cmd_write, cmd_len, err_timeout}, {1'b1, 1'b1, 32'd2, 1'b1});
    wr_req = 1'b0;
    cyc();
    complete();
    check("to_sticky", err_timeout, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("to_rst_clear", err_timeout, 1'b0);
`else
    complete();
    check("err_tied_low", err_timeout, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
